// File: rtl/trap_arbiter.sv
// trap_arbiter: front-end controller for the machine-mode trap handler.
// Arbitrates exceptions, mret and machine interrupts in IDLE, runs the
// pipeline flush handshake, issues one exc_en/irq_en pulse per trap and
// waits (bounded) for trap_taken. mret is followed by a settle cycle with
// no arbitration.
// Optional feature macro: TRAP_ARBITER_NMI_EN (adds nmi_req, highest priority).
module trap_arbiter #(
    parameter int unsigned TAKEN_TIMEOUT = 8,
    parameter int unsigned XLEN          = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code_in,
    input  logic [XLEN-1:0] exc_val_in,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] cur_pc,
    input  logic [2:0]      mip_in,
    input  logic [2:0]      mie_in,
    input  logic            mstatus_mie,
    input  logic            mret_req,
    input  logic            flush_ack,
    input  logic            trap_taken,
`ifdef TRAP_ARBITER_NMI_EN
    input  logic            nmi_req,
`endif
    output logic            flush_req,
    output logic            exc_en,
    output logic            irq_en,
    output logic [3:0]      exc_code,
    output logic [3:0]      irq_code,
    output logic [XLEN-1:0] exc_val,
    output logic [XLEN-1:0] irq_val,
    output logic [XLEN-1:0] pc_addr,
    output logic            mret,
    output logic            busy,
    output logic            timeout_err
);

    // ISSUE is the cycle between flush completion and the pulse;
    // MRET carries the mret pulse, MRET_HOLD is the settle cycle after it.
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_ISSUE, S_WAIT_TAKEN, S_MRET, S_MRET_HOLD
    } state_t;

    state_t          state, state_n;
    logic            lat_irq, lat_irq_n;
    logic [3:0]      lat_code, lat_code_n;
    logic [XLEN-1:0] lat_val, lat_val_n;
    logic [XLEN-1:0] lat_pc, lat_pc_n;
    logic [7:0]      cnt, cnt_n;

    logic            flush_req_n, exc_en_n, irq_en_n, mret_n, timeout_err_n;
    logic [3:0]      exc_code_n, irq_code_n;
    logic [XLEN-1:0] exc_val_n, pc_addr_n;

    logic [2:0]      irq_pend;
    assign irq_pend = mip_in & mie_in & {3{mstatus_mie}};

`ifdef TRAP_ARBITER_NMI_EN
    logic nmi_d, nmi_pend, lat_nmi, lat_nmi_n, nmi_clr;

    // NMI rising-edge capture; pending clears when its irq_en issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmi_d    <= 1'b0;
            nmi_pend <= 1'b0;
            lat_nmi  <= 1'b0;
        end else begin
            nmi_d   <= nmi_req;
            lat_nmi <= lat_nmi_n;
            if (nmi_req && !nmi_d)
                nmi_pend <= 1'b1;
            else if (nmi_clr)
                nmi_pend <= 1'b0;
        end
    end
`endif

    // State, latches and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            lat_irq     <= 1'b0;
            lat_code    <= '0;
            lat_val     <= '0;
            lat_pc      <= '0;
            cnt         <= '0;
            flush_req   <= 1'b0;
            exc_en      <= 1'b0;
            irq_en      <= 1'b0;
            exc_code    <= '0;
            irq_code    <= '0;
            exc_val     <= '0;
            irq_val     <= '0;
            pc_addr     <= '0;
            mret        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            lat_irq     <= lat_irq_n;
            lat_code    <= lat_code_n;
            lat_val     <= lat_val_n;
            lat_pc      <= lat_pc_n;
            cnt         <= cnt_n;
            flush_req   <= flush_req_n;
            exc_en      <= exc_en_n;
            irq_en      <= irq_en_n;
            exc_code    <= exc_code_n;
            irq_code    <= irq_code_n;
            exc_val     <= exc_val_n;
            irq_val     <= '0;
            pc_addr     <= pc_addr_n;
            mret        <= mret_n;
            busy        <= (state_n != S_IDLE);
            timeout_err <= timeout_err_n;
        end
    end

    // Arbitration, handshake sequencing and next-output computation
    always_comb begin
        state_n       = state;
        lat_irq_n     = lat_irq;
        lat_code_n    = lat_code;
        lat_val_n     = lat_val;
        lat_pc_n      = lat_pc;
        cnt_n         = cnt;
        flush_req_n   = 1'b0;
        exc_en_n      = 1'b0;
        irq_en_n      = 1'b0;
        exc_code_n    = '0;
        irq_code_n    = '0;
        exc_val_n     = '0;
        pc_addr_n     = '0;
        mret_n        = 1'b0;
        timeout_err_n = timeout_err;
`ifdef TRAP_ARBITER_NMI_EN
        lat_nmi_n     = lat_nmi;
        nmi_clr       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
`ifdef TRAP_ARBITER_NMI_EN
                if (nmi_pend) begin
                    lat_irq_n   = 1'b1;
                    lat_nmi_n   = 1'b1;
                    lat_code_n  = 4'd0;
                    lat_val_n   = '0;
                    lat_pc_n    = cur_pc;
                    flush_req_n = 1'b1;
                    state_n     = S_FLUSH;
                end else
`endif
                if (exc_valid) begin
                    lat_irq_n   = 1'b0;
                    lat_code_n  = exc_code_in;
                    lat_val_n   = exc_val_in;
                    lat_pc_n    = exc_pc;
                    flush_req_n = 1'b1;
                    state_n     = S_FLUSH;
`ifdef TRAP_ARBITER_NMI_EN
                    lat_nmi_n   = 1'b0;
`endif
                end else if (mret_req) begin
                    mret_n  = 1'b1;
                    state_n = S_MRET;
                end else if (|irq_pend) begin
                    lat_irq_n   = 1'b1;
                    lat_code_n  = irq_pend[2] ? 4'd11 : (irq_pend[0] ? 4'd3 : 4'd7);
                    lat_val_n   = '0;
                    lat_pc_n    = cur_pc;
                    flush_req_n = 1'b1;
                    state_n     = S_FLUSH;
`ifdef TRAP_ARBITER_NMI_EN
                    lat_nmi_n   = 1'b0;
`endif
                end
            end
            S_FLUSH: begin
                if (flush_ack)
                    state_n = S_ISSUE;
                else
                    flush_req_n = 1'b1;
            end
            S_ISSUE: begin
                if (lat_irq) begin
                    irq_en_n   = 1'b1;
                    irq_code_n = lat_code;
                end else begin
                    exc_en_n   = 1'b1;
                    exc_code_n = lat_code;
                    exc_val_n  = lat_val;
                end
                pc_addr_n = lat_pc;
                cnt_n     = '0;
                state_n   = S_WAIT_TAKEN;
`ifdef TRAP_ARBITER_NMI_EN
                nmi_clr   = lat_nmi;
`endif
            end
            S_WAIT_TAKEN: begin
                if (trap_taken) begin
                    state_n = S_IDLE;
                end else if (cnt == 8'(TAKEN_TIMEOUT - 1)) begin
                    timeout_err_n = 1'b1;
                    state_n       = S_IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_MRET:      state_n = S_MRET_HOLD;
            S_MRET_HOLD: state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter: directed scenarios plus randomized
// arbitration checked against a priority-list reference model.
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [3:0]  exc_code_in;
    logic [63:0] exc_val_in, exc_pc, cur_pc;
    logic [2:0]  mip_in, mie_in;
    logic        mstatus_mie, mret_req, flush_ack, trap_taken;
    logic        nmi_req = 1'b0;
    logic        flush_req, exc_en, irq_en, mret, busy, timeout_err;
    logic [3:0]  exc_code, irq_code;
    logic [63:0] exc_val, irq_val, pc_addr;

    int n_checks = 0;
    int n_pass   = 0;

    trap_arbiter #(.TAKEN_TIMEOUT(8), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_code_in(exc_code_in),
        .exc_val_in(exc_val_in), .exc_pc(exc_pc), .cur_pc(cur_pc), .mip_in(mip_in),
        .mie_in(mie_in), .mstatus_mie(mstatus_mie), .mret_req(mret_req),
        .flush_ack(flush_ack), .trap_taken(trap_taken),
`ifdef TRAP_ARBITER_NMI_EN
        .nmi_req(nmi_req),
`endif
        .flush_req(flush_req), .exc_en(exc_en), .irq_en(irq_en), .exc_code(exc_code),
        .irq_code(irq_code), .exc_val(exc_val), .irq_val(irq_val), .pc_addr(pc_addr),
        .mret(mret), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: kind 0 none, 1 exception, 2 interrupt, 3 mret
    function automatic void ref_select(input logic ev, input logic [3:0] ec,
                                       input logic [2:0] mip, input logic [2:0] mie,
                                       input logic gie, input logic mr,
                                       output int kind, output logic [3:0] code);
        int unsigned pbit[3];
        int unsigned pcode[3];
        pbit  = '{2, 0, 1};
        pcode = '{11, 3, 7};
        kind = 0;
        code = 4'd0;
        if (ev) begin
            kind = 1;
            code = ec;
            return;
        end
        if (mr) begin
            kind = 3;
            return;
        end
        if (gie) begin
            for (int i = 0; i < 3; i++) begin
                if (mip[pbit[i]] && mie[pbit[i]]) begin
                    kind = 2;
                    code = 4'(pcode[i]);
                    return;
                end
            end
        end
    endfunction

    task automatic clear_inputs();
        exc_valid = 0; exc_code_in = 0; exc_val_in = 0; exc_pc = 0; cur_pc = 0;
        mip_in = 0; mie_in = 0; mstatus_mie = 0; mret_req = 0; flush_ack = 0;
        trap_taken = 0;
    endtask

    // Runs one trap from the selection edge through trap_taken.
    // Inputs for the selection edge must already be driven.
    task automatic run_trap(input int kind, input logic [3:0] ecode, input logic [63:0] eval,
                            input logic [63:0] epc, input int ack_delay, input int taken_delay);
        tick();
        n_checks++;
        if (flush_req !== 1'b1 || busy !== 1'b1 || mret !== 1'b0)
            $display("FAIL select: flush_req=%b busy=%b mret=%b, want 1 1 0", flush_req, busy, mret);
        else n_pass++;
        // scramble inputs: latched values must not follow them
        exc_valid = 0; exc_code_in = 4'($urandom); exc_val_in = {$urandom, $urandom};
        exc_pc = {$urandom, $urandom}; cur_pc = {$urandom, $urandom}; mip_in = 0;
        mret_req = 1'($urandom);
        for (int i = 0; i < ack_delay; i++) begin
            flush_ack = 0;
            tick();
            n_checks++;
            if (flush_req !== 1'b1 || exc_en !== 1'b0 || irq_en !== 1'b0)
                $display("FAIL flush_hold: flush_req=%b exc_en=%b irq_en=%b, want 1 0 0", flush_req, exc_en, irq_en);
            else n_pass++;
        end
        flush_ack = 1;
        tick();
        n_checks++;
        if (flush_req !== 1'b0 || exc_en !== 1'b0 || irq_en !== 1'b0 || mret !== 1'b0)
            $display("FAIL flush_done: flush_req=%b exc_en=%b irq_en=%b mret=%b, want 0 0 0 0", flush_req, exc_en, irq_en, mret);
        else n_pass++;
        flush_ack = 0;
        mret_req  = 0;
        tick();
        n_checks++;
        if (kind == 1) begin
            if (exc_en !== 1'b1 || irq_en !== 1'b0 || exc_code !== ecode || exc_val !== eval || pc_addr !== epc)
                $display("FAIL exc_pulse: en=%b/%b code=%0d val=%h pc=%h, want 1/0 code=%0d val=%h pc=%h",
                         exc_en, irq_en, exc_code, exc_val, pc_addr, ecode, eval, epc);
            else n_pass++;
        end else begin
            if (irq_en !== 1'b1 || exc_en !== 1'b0 || irq_code !== ecode || irq_val !== 64'd0 || pc_addr !== epc)
                $display("FAIL irq_pulse: en=%b/%b code=%0d val=%h pc=%h, want 0/1 code=%0d val=0 pc=%h",
                         exc_en, irq_en, irq_code, irq_val, pc_addr, ecode, epc);
            else n_pass++;
        end
        for (int i = 0; i < taken_delay; i++) begin
            tick();
            n_checks++;
            if (exc_en !== 1'b0 || irq_en !== 1'b0 || busy !== 1'b1)
                $display("FAIL wait_taken: exc_en=%b irq_en=%b busy=%b, want 0 0 1", exc_en, irq_en, busy);
            else n_pass++;
        end
        trap_taken = 1;
        tick();
        trap_taken = 0;
        n_checks++;
        if (busy !== 1'b0 || exc_en !== 1'b0 || irq_en !== 1'b0 || flush_req !== 1'b0)
            $display("FAIL taken_return: busy=%b exc_en=%b irq_en=%b flush_req=%b, want 0 0 0 0", busy, exc_en, irq_en, flush_req);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        n_checks++;
        if ({flush_req, exc_en, irq_en, exc_code, irq_code, exc_val, irq_val, pc_addr, mret, busy, timeout_err} !== '0)
            $display("FAIL reset_outputs: some output nonzero (busy=%b flush_req=%b pc=%h), want all 0", busy, flush_req, pc_addr);
        else n_pass++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_exception();
        exc_valid = 1; exc_code_in = 4'd2; exc_val_in = 64'hDEAD; exc_pc = 64'h100;
        run_trap(1, 4'd2, 64'hDEAD, 64'h100, 0, 0);
    endtask

    task automatic test_irq_priority();
        logic [2:0]  mies[3];
        logic [3:0]  codes[3];
        logic [63:0] pc;
        mies  = '{3'b111, 3'b011, 3'b010};
        codes = '{4'd11, 4'd3, 4'd7};
        for (int i = 0; i < 3; i++) begin
            pc = {$urandom, $urandom};
            mip_in = 3'b111; mie_in = mies[i]; mstatus_mie = 1; cur_pc = pc;
            run_trap(2, codes[i], 64'd0, pc, 0, 0);
        end
        // global enable off: nothing is selected
        mip_in = 3'b111; mie_in = 3'b111; mstatus_mie = 0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0)
            $display("FAIL irq_gated: busy=%b flush_req=%b, want 0 0", busy, flush_req);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_exc_over_irq();
        logic [63:0] pc;
        exc_valid = 1; exc_code_in = 4'd3; exc_val_in = 64'h55; exc_pc = 64'h2000;
        mip_in = 3'b010; mie_in = 3'b010; mstatus_mie = 1; mret_req = 1;
        run_trap(1, 4'd3, 64'h55, 64'h2000, 1, 2);
        pc = 64'h3000;
        mip_in = 3'b010; cur_pc = pc;
        run_trap(2, 4'd7, 64'd0, pc, 0, 1);
        clear_inputs();
    endtask

    task automatic test_mret_hold();
        mret_req = 1; mip_in = 3'b111; mie_in = 3'b111; mstatus_mie = 1; cur_pc = 64'h4444;
        tick();
        mret_req = 0;
        n_checks++;
        if (mret !== 1'b1 || busy !== 1'b1 || flush_req !== 1'b0)
            $display("FAIL mret_pulse: mret=%b busy=%b flush_req=%b, want 1 1 0", mret, busy, flush_req);
        else n_pass++;
        tick();
        n_checks++;
        if (mret !== 1'b0 || busy !== 1'b1 || flush_req !== 1'b0)
            $display("FAIL mret_hold: mret=%b busy=%b flush_req=%b, want 0 1 0", mret, busy, flush_req);
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0)
            $display("FAIL mret_exit: busy=%b flush_req=%b, want 0 0", busy, flush_req);
        else n_pass++;
        run_trap(2, 4'd11, 64'd0, 64'h4444, 0, 0);
        clear_inputs();
    endtask

    task automatic test_random();
        int          kind;
        logic [3:0]  code;
        logic [63:0] v, pc;
        for (int it = 0; it < 40; it++) begin
            exc_valid   = ($urandom_range(0, 2) == 0);
            exc_code_in = 4'($urandom);
            exc_val_in  = {$urandom, $urandom};
            exc_pc      = {$urandom, $urandom};
            cur_pc      = {$urandom, $urandom};
            mip_in      = 3'($urandom);
            mie_in      = 3'($urandom);
            mstatus_mie = 1'($urandom);
            mret_req    = ($urandom_range(0, 3) == 0);
            ref_select(exc_valid, exc_code_in, mip_in, mie_in, mstatus_mie, mret_req, kind, code);
            v  = exc_val_in;
            pc = (kind == 1) ? exc_pc : cur_pc;
            if (kind == 1 || kind == 2) begin
                run_trap(kind, code, v, pc, $urandom_range(0, 3), $urandom_range(0, 7));
            end else if (kind == 3) begin
                tick();
                mret_req = 0;
                n_checks++;
                if (mret !== 1'b1 || busy !== 1'b1 || flush_req !== 1'b0)
                    $display("FAIL rnd_mret: mret=%b busy=%b flush_req=%b, want 1 1 0", mret, busy, flush_req);
                else n_pass++;
                tick();
                tick();
                n_checks++;
                if (busy !== 1'b0 || flush_req !== 1'b0 || mret !== 1'b0)
                    $display("FAIL rnd_mret_exit: busy=%b flush_req=%b mret=%b, want 0 0 0", busy, flush_req, mret);
                else n_pass++;
            end else begin
                tick();
                n_checks++;
                if (busy !== 1'b0 || flush_req !== 1'b0 || mret !== 1'b0)
                    $display("FAIL rnd_idle: busy=%b flush_req=%b mret=%b, want 0 0 0", busy, flush_req, mret);
                else n_pass++;
            end
            clear_inputs();
        end
    endtask

    task automatic test_timeout();
        exc_valid = 1; exc_code_in = 4'd5; exc_val_in = 64'h9; exc_pc = 64'h500;
        tick();
        exc_valid = 0;
        flush_ack = 1;
        tick();
        flush_ack = 0;
        tick();
        n_checks++;
        if (exc_en !== 1'b1 || exc_code !== 4'd5)
            $display("FAIL to_pulse: exc_en=%b code=%0d, want 1 5", exc_en, exc_code);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b1 || timeout_err !== 1'b0)
                $display("FAIL to_wait: cycle %0d busy=%b timeout_err=%b, want 1 0", i, busy, timeout_err);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1)
            $display("FAIL to_abort: busy=%b timeout_err=%b, want 0 1", busy, timeout_err);
        else n_pass++;
        exc_valid = 1; exc_code_in = 4'd1; exc_val_in = 64'h7; exc_pc = 64'h600;
        run_trap(1, 4'd1, 64'h7, 64'h600, 0, 0);
        n_checks++;
        if (timeout_err !== 1'b1)
            $display("FAIL to_sticky: timeout_err=%b, want 1", timeout_err);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_reset_mid_flush();
        int pulses = 0;
        exc_valid = 1; exc_code_in = 4'd4; exc_val_in = 64'hAB; exc_pc = 64'h700;
        tick();
        exc_valid = 0;
        n_checks++;
        if (flush_req !== 1'b1)
            $display("FAIL rst_flush_enter: flush_req=%b, want 1", flush_req);
        else n_pass++;
        rst_n = 0;
        tick();
        n_checks++;
        if ({flush_req, exc_en, irq_en, exc_code, irq_code, exc_val, irq_val, pc_addr, mret, busy, timeout_err} !== '0)
            $display("FAIL rst_mid_flush: busy=%b flush_req=%b timeout_err=%b pc=%h, want all 0", busy, flush_req, timeout_err, pc_addr);
        else n_pass++;
        rst_n = 1;
        flush_ack = 1;
        trap_taken = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (exc_en || irq_en || busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0)
            $display("FAIL rst_no_pulse: %0d active cycles after reset, want 0", pulses);
        else n_pass++;
        clear_inputs();
    endtask

    // Watch for overlapping pulses across the whole run
    always @(negedge clk) begin
        if (rst_n && exc_en && irq_en) begin
            n_checks++;
            $display("FAIL pulse_overlap: exc_en=1 irq_en=1, want never both");
        end
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_exception();
        test_irq_priority();
        test_exc_over_irq();
        test_mret_hold();
        test_random();
        test_timeout();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, want completion");
        $fatal(1, "bench timeout");
    end

endmodule
